// File: rtl/sprite_draw.sv
// Sprite overlay stage: looks up a ROM sprite at a frame-latched position and
// merges it into the VGA timing bus with a fixed 3-cycle latency.
`timescale 1ns/1ps
`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 40
`endif

module sprite_draw #(
    parameter int          SPR_W      = 75,
    parameter int          SPR_H      = 89,
    parameter int          ADDR_W     = 14,
    parameter int          PIX_W      = 4,
    parameter int          TRANSP_KEY = 0,
    parameter int          MODE       = 1,
    parameter logic [11:0] COL_HI     = 12'hFFF,
    parameter logic [11:0] COL_LO     = 12'hABC
) (
    input  logic                      pclk,
    input  logic                      rst,
    input  logic [11:0]               xpos,
    input  logic [11:0]               ypos,
    input  logic                      mirror,
    input  logic                      enable,
    input  logic [`VGA_BUS_SIZE-1:0]  vga_in,
    output logic [`VGA_BUS_SIZE-1:0]  vga_out,
    output logic [ADDR_W-1:0]         pixel_addr,
    input  logic [PIX_W-1:0]          rgb_pixel,
    output logic                      sprite_hit
);

    // Bus layout: {hcount 12, hs, hblnk, vcount 12, vs, vblnk, rgb 12}
    localparam int HC_LSB = 28;
    localparam int HB_BIT = 26;
    localparam int VC_LSB = 14;
    localparam int VB_BIT = 12;

    logic [11:0] xs, ys;
    logic        mir_s, en_s;
    logic        vblnk_d;

    logic [`VGA_BUS_SIZE-1:0] vga_d1, vga_d2;
    logic                     inside1, inside2;

    // Position/control only change at the start of vertical blanking.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            xs      <= '0;
            ys      <= '0;
            mir_s   <= 1'b0;
            en_s    <= 1'b0;
            vblnk_d <= 1'b0;
        end else begin
            vblnk_d <= vga_in[VB_BIT];
            if (vga_in[VB_BIT] && !vblnk_d) begin
                xs    <= xpos;
                ys    <= ypos;
                mir_s <= mirror;
                en_s  <= enable;
            end
        end
    end

    logic [12:0]       hc13, vc13, xs13, ys13, x_end, y_end;
    logic [12:0]       col, row, col_m;
    logic              inside0;
    logic [ADDR_W-1:0] addr_next;

    // 13-bit arithmetic keeps a sprite near the right/bottom edge from wrapping.
    always_comb begin
        hc13      = {1'b0, vga_in[HC_LSB +: 12]};
        vc13      = {1'b0, vga_in[VC_LSB +: 12]};
        xs13      = {1'b0, xs};
        ys13      = {1'b0, ys};
        x_end     = xs13 + 13'(SPR_W);
        y_end     = ys13 + 13'(SPR_H);
        inside0   = (hc13 >= xs13) && (hc13 < x_end) && (vc13 >= ys13) && (vc13 < y_end);
        col       = hc13 - xs13;
        row       = vc13 - ys13;
        col_m     = mir_s ? (13'(SPR_W - 1) - col) : col;
        addr_next = ADDR_W'(row) * ADDR_W'(SPR_W) + ADDR_W'(col_m);
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            pixel_addr <= '0;
            vga_d1     <= '0;
            vga_d2     <= '0;
            inside1    <= 1'b0;
            inside2    <= 1'b0;
        end else begin
            vga_d1  <= vga_in;
            inside1 <= inside0;
            if (inside0)
                pixel_addr <= addr_next;
            vga_d2  <= vga_d1;
            inside2 <= inside1;
        end
    end

    logic [11:0] spr_rgb;

    generate
        if (MODE == 0) begin : g_grey
            logic [3:0] nib;
            if (PIX_W >= 4) begin : g_wide
                assign nib = rgb_pixel[PIX_W-1 -: 4];
            end else begin : g_narrow
                assign nib = {rgb_pixel, {(4-PIX_W){1'b0}}};
            end
            assign spr_rgb = {nib, nib, nib};
        end else begin : g_two
            assign spr_rgb = (&rgb_pixel) ? COL_HI : COL_LO;
        end
    endgenerate

    logic draw;

    always_comb begin
        draw = !vga_d2[HB_BIT] && !vga_d2[VB_BIT] && inside2 && en_s
               && (rgb_pixel != PIX_W'(TRANSP_KEY));
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            vga_out    <= '0;
            sprite_hit <= 1'b0;
        end else begin
            vga_out    <= draw ? {vga_d2[`VGA_BUS_SIZE-1:12], spr_rgb} : vga_d2;
            sprite_hit <= draw;
        end
    end

endmodule

// File: tb/tb_sprite_draw.sv
// Bench for sprite_draw: randomized and directed frames, a reference model of
// the sprite rules, and a scoreboard checked from an independent monitor.
`timescale 1ns/1ps
`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 40
`endif

module tb_sprite_draw;

    localparam int W = 75;
    localparam int H = 89;

    logic        pclk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] xpos = '0, ypos = '0;
    logic        mirror = 1'b0, enable = 1'b0;
    logic [39:0] vga_in = '0;
    logic [39:0] vga_out;
    logic [13:0] pixel_addr;
    logic [3:0]  rgb_pixel = '0;
    logic        sprite_hit;

    sprite_draw dut (
        .pclk(pclk), .rst(rst), .xpos(xpos), .ypos(ypos), .mirror(mirror),
        .enable(enable), .vga_in(vga_in), .vga_out(vga_out),
        .pixel_addr(pixel_addr), .rgb_pixel(rgb_pixel), .sprite_hit(sprite_hit)
    );

    always #5 pclk = ~pclk;

    logic [3:0] rom [0:16383];
    always @(posedge pclk) rgb_pixel <= rom[pixel_addr];

    int ecnt = 0;
    always @(posedge pclk) ecnt <= ecnt + 1;

    typedef struct { int due; logic [39:0] vga; logic hit; } out_t;
    typedef struct { int due; logic [13:0] a; } addr_t;
    out_t  oq[$];
    addr_t aq[$];

    int n_tests = 0, n_fail = 0, n_print = 0, hits = 0;

    // reference model state
    int sx = 0, sy = 0, last_addr = 0;
    bit sm = 0, se = 0, prev_vb = 0;
    bit use_fix = 0;

    task automatic chk(string nm, logic [39:0] act, logic [39:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic px(int h, int v, bit hb, bit vb, logic [11:0] rgb);
        logic [39:0] w, e;
        int hh, vv, col, pix;
        bit ins, hit;
        @(posedge pclk); #1;
        w = {12'(h), 1'($urandom), hb, 12'(v), 1'($urandom), vb, rgb};
        vga_in = w;
        hh  = int'(w[39:28]);
        vv  = int'(w[25:14]);
        ins = (hh >= sx) && (hh < sx + W) && (vv >= sy) && (vv < sy + H);
        pix = 0;
        if (ins) begin
            col = hh - sx;
            if (sm) col = W - 1 - col;
            last_addr = (vv - sy) * W + col;
            pix = int'(rom[last_addr]);
        end
        aq.push_back(addr_t'{due: ecnt + 1, a: 14'(last_addr)});
        if (hb || vb || !ins || !se || pix == 0) begin
            e = w; hit = 0;
        end else begin
            e = {w[39:12], (pix == 15) ? 12'hFFF : 12'hABC}; hit = 1;
        end
        oq.push_back(out_t'{due: ecnt + 3, vga: e, hit: hit});
        if (vb && !prev_vb) begin
            sx = int'(xpos); sy = int'(ypos); sm = mirror; se = enable;
        end
        prev_vb = vb;
    endtask

    function automatic logic [11:0] bg();
        return use_fix ? 12'h123 : 12'($urandom);
    endfunction

    task automatic line(int v, int h0, int h1);
        for (int h = h0; h <= h1; h++) px(h, v, 0, 0, bg());
        for (int k = 1; k <= 4; k++) px(h1 + k, v, 1, 0, bg());
    endtask

    task automatic vblank();
        for (int i = 0; i < 6; i++) px(i, 600, 1, 1, bg());
    endtask

    task automatic probe(int h, int v, int exp, string nm);
        px(h, v, 0, 0, bg());
        px(h + 1, v, 0, 0, bg());
        chk(nm, 40'(pixel_addr), 40'(exp));
    endtask

    task automatic probe_out(int h, int v, logic [11:0] exp_rgb, bit exp_hit, string nm);
        px(h, v, 0, 0, 12'h123);
        for (int i = 1; i <= 3; i++) px(h + i, v, 1, 0, 12'h123);
        chk({nm, "_rgb"}, 40'(vga_out[11:0]), 40'(exp_rgb));
        chk({nm, "_hit"}, 40'(sprite_hit), 40'(exp_hit));
    endtask

    task automatic rom_lsb();
        for (int a = 0; a < 16384; a++) rom[a] = 4'(a);
    endtask

    task automatic rom_eo();
        for (int a = 0; a < 16384; a++) rom[a] = (a % 2 == 1) ? 4'hF : 4'h0;
    endtask

    task automatic rom_rand();
        for (int a = 0; a < 16384; a++) rom[a] = 4'($urandom_range(0, 3) == 0 ? 0 : $urandom);
    endtask

    always @(negedge pclk) begin
        out_t  e;
        addr_t a;
        if (rst) begin
            if (oq.size() > 0 && oq[0].due == ecnt) begin
                e = oq.pop_front();
                n_tests++;
                if (sprite_hit) hits++;
                if (vga_out !== e.vga || sprite_hit !== e.hit) begin
                    n_fail++;
                    if (n_print < 20)
                        $display("FAIL out cyc %0d: got vga=%h hit=%b expected vga=%h hit=%b",
                                 ecnt, vga_out, sprite_hit, e.vga, e.hit);
                    n_print++;
                end
            end
            if (aq.size() > 0 && aq[0].due == ecnt) begin
                a = aq.pop_front();
                n_tests++;
                if (pixel_addr !== a.a) begin
                    n_fail++;
                    if (n_print < 20)
                        $display("FAIL addr cyc %0d: got %0d expected %0d", ecnt, pixel_addr, a.a);
                    n_print++;
                end
            end
        end
    end

    initial begin
        int h0, hold_a, vc, hs;
        for (int a = 0; a < 16384; a++) rom[a] = 4'h0;
        repeat (3) @(posedge pclk);
        #1;
        chk("rst_vga", vga_out, 40'h0);
        chk("rst_addr", 40'(pixel_addr), 40'h0);
        chk("rst_hit", 40'(sprite_hit), 40'h0);
        #2 rst = 1'b1;

        // scenario 1: plain placement and latency
        xpos = 100; ypos = 50; enable = 1; mirror = 0;
        rom_lsb();
        vblank();
        px(1234, 700, 1, 0, 12'h321);
        px(1, 700, 1, 0, 12'h0);
        px(2, 700, 1, 0, 12'h0);
        chk("lat_early", 40'(vga_out[39:28] == 12'd1234), 40'h0);
        px(3, 700, 1, 0, 12'h0);
        chk("lat_3", 40'(vga_out[39:28]), 40'd1234);
        line(49, 90, 180);
        line(50, 90, 180);
        probe(100, 50, 0, "s1_addr_first");
        probe(174, 138, 6674, "s1_addr_last");
        line(138, 90, 180);
        line(139, 90, 180);

        // scenario 2: mirrored
        mirror = 1;
        vblank();
        probe(100, 50, 74, "s2_addr_left");
        probe(174, 50, 0, "s2_addr_right");
        line(50, 90, 180);
        line(100, 90, 180);

        // scenario 3: transparency key
        mirror = 0; use_fix = 1;
        vblank();
        rom_eo();
        line(60, 95, 180);
        probe_out(101, 60, 12'hFFF, 1, "s3_odd");
        probe_out(100, 60, 12'h123, 0, "s3_even");

        // scenario 4: mid-frame move
        use_fix = 0;
        vblank();
        rom_lsb();
        line(50, 90, 180);
        xpos = 300;
        line(51, 90, 400);
        probe_out(101, 52, 12'hABC, 1, "s4_old_pos");
        probe_out(301, 52, 12'h123, 0, "s4_not_yet");
        vblank();
        line(52, 90, 400);
        probe_out(301, 52, 12'hABC, 1, "s4_new_pos");
        probe_out(101, 52, 12'h123, 0, "s4_old_gone");

        // scenario 5: right-edge sprite must not wrap onto the left
        xpos = 4090;
        vblank();
        h0 = hits;
        hold_a = int'(pixel_addr);
        line(60, 0, 120);
        line(100, 0, 120);
        chk("s5_no_hits", 40'(hits - h0), 40'h0);
        chk("s5_addr_hold", 40'(pixel_addr), 40'(hold_a));

        // scenario 6: reset mid-line
        xpos = 0; ypos = 0;
        vblank();
        for (int h = 95; h <= 120; h++) px(h, 60, 0, 0, bg());
        @(posedge pclk); #3;
        rst = 1'b0;
        #1;
        chk("s6_vga_zero", vga_out, 40'h0);
        chk("s6_hit_zero", 40'(sprite_hit), 40'h0);
        chk("s6_addr_zero", 40'(pixel_addr), 40'h0);
        oq.delete(); aq.delete();
        sx = 0; sy = 0; sm = 0; se = 0; prev_vb = 0; last_addr = 0;
        repeat (3) @(posedge pclk);
        #3 rst = 1'b1;
        h0 = hits;
        line(10, 0, 100);
        line(20, 0, 100);
        chk("s6_no_draw", 40'(hits - h0), 40'h0);
        vblank();
        line(10, 0, 100);
        chk("s6_draw_after", 40'(hits > h0), 40'h1);

        // randomized frames
        for (int f = 0; f < 6; f++) begin
            xpos = 12'($urandom_range(0, 300));
            ypos = 12'($urandom_range(0, 150));
            mirror = 1'($urandom);
            enable = ($urandom_range(0, 3) != 0);
            vblank();
            rom_rand();
            for (int l = 0; l < 6; l++) begin
                vc = int'(ypos) + $urandom_range(0, 100) - 5;
                if (vc < 0) vc = 0;
                hs = int'(xpos) - 10;
                if (hs < 0) hs = 0;
                line(vc, hs, hs + 95);
                if (l == 2) xpos = 12'($urandom_range(0, 300));
            end
        end

        repeat (5) @(posedge pclk);
        #1;
        chk("drain", 40'(oq.size() + aq.size()), 40'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_draw.md
SPRITE_DRAW -- requirements
Module: sprite_draw

Interface
REQ-001 The module SHALL have parameter SPR_W, default 75, meaning sprite width in pixels.
REQ-002 The module SHALL have parameter SPR_H, default 89, meaning sprite height in pixels.
REQ-003 The module SHALL have parameter ADDR_W, default 14, meaning ROM address width, with SPR_W*SPR_H <= 2**ADDR_W.
REQ-004 The module SHALL have parameter PIX_W, default 4, meaning ROM pixel width.
REQ-005 The module SHALL have parameter TRANSP_KEY, default 0, meaning the pixel value rendered as transparent.
REQ-006 The module SHALL have parameter MODE, default 1, meaning 0 = grey expand, 1 = two-colour.
REQ-007 The module SHALL have parameters COL_HI, default 12'hFFF, and COL_LO, default 12'hABC, meaning the MODE 1 colours.
REQ-008 pclk  in  1  pixel clock; all logic runs on its rising edge.
REQ-009 rst  in  1  reset, asynchronous and active-low.
REQ-010 xpos  in  12  sprite left edge, in screen pixels.
REQ-011 ypos  in  12  sprite top edge, in screen pixels.
REQ-012 mirror  in  1  horizontal flip; 1 means the sprite faces left.
REQ-013 enable  in  1  draw enable.
REQ-014 vga_in  in  `VGA_BUS_SIZE  timing bus {hcount 12, hs, hblnk, vcount 12, vs, vblnk, rgb 12}.
REQ-015 vga_out  out  `VGA_BUS_SIZE  same field layout as vga_in.
REQ-016 pixel_addr  out  ADDR_W  address to a synchronous ROM with 1-cycle read latency.
REQ-017 rgb_pixel  in  PIX_W  ROM data, valid one cycle after pixel_addr.
REQ-018 sprite_hit  out  1  high when the vga_out pixel is an opaque sprite pixel.

Function
REQ-019 vga_out timing fields (hcount, hs, hblnk, vcount, vs, vblnk) SHALL equal vga_in delayed exactly 3 pclk cycles.
REQ-020 xpos, ypos, mirror and enable SHALL be captured into shadow registers only on the first cycle vga_in.vblnk is 1 after being 0; the shadows SHALL hold at all other times, so no mid-frame tearing occurs.
REQ-021 Stage 1: inside = (hcount >= xs) && (hcount < xs+SPR_W) && (vcount >= ys) && (vcount < ys+SPR_H), where xs/ys are the shadow positions and all sums are 13-bit, so a sprite at xpos 4090 does not wrap.
REQ-022 Stage 1: when inside, row = vcount-ys and col = hcount-xs; col' = SPR_W-1-col if the mirror shadow is set, else col; pixel_addr is registered as row*SPR_W+col'.
REQ-023 Stage 1: when outside, pixel_addr SHALL hold its previous value.
REQ-024 The inside flag SHALL be pipelined 2 further stages, aligned with rgb_pixel and rgb_in.
REQ-025 Output stage: if hblnk or vblnk (delayed), or not inside, or the enable shadow is 0, or rgb_pixel == TRANSP_KEY, then rgb_out SHALL be rgb_in delayed and sprite_hit SHALL be 0.
REQ-026 Otherwise, with MODE 0, rgb_out SHALL be the top 4 bits of rgb_pixel replicated into R, G and B (zero-padded if PIX_W < 4).
REQ-027 Otherwise, with MODE 1, rgb_out SHALL be COL_HI when rgb_pixel is all ones and COL_LO otherwise.
REQ-028 Otherwise, sprite_hit SHALL be 1.
REQ-029 Parts of the sprite extending past the visible area SHALL be clipped by blanking; no address wrap or artefacts SHALL occur.
REQ-030 Position changes while vblnk is already high SHALL take effect at the next vblnk rising edge.

Reset
REQ-031 While rst is 0, all vga_out fields, pixel_addr, sprite_hit, the pipeline registers and the shadows (mirror = 0, enable = 0) SHALL be 0, asynchronously.
REQ-032 Release of rst SHALL be synchronous to pclk; the first capture SHALL occur at the next vblnk rise, so no sprite is drawn in the first partial frame.
REQ-033 Reset asserted mid-frame SHALL force vga_out to 0 within the same cycle.

Verification
REQ-034 Scenario 1: xpos=100, ypos=50, enable=1, mirror=0, ROM = address LSBs -> at pixel (100,50) pixel_addr=0; at (174,138) pixel_addr=6674; vga_out lags vga_in by 3 cycles.
REQ-035 Scenario 2: same setup with mirror=1 -> at (100,50) pixel_addr=74; at (174,50) pixel_addr=0.
REQ-036 Scenario 3: ROM = 0 (TRANSP_KEY) on even addresses and 4'hF elsewhere, background rgb 12'h123 -> odd pixels 12'hFFF with sprite_hit=1; even pixels 12'h123 with sprite_hit=0.
REQ-037 Scenario 4: change xpos from 100 to 300 mid-frame -> the current frame still draws at 100 and the next frame draws at 300.
REQ-038 Scenario 5: xpos=4090 -> no pixels are drawn at hcount 0-69 and the inside flag never asserts.
REQ-039 Scenario 6: assert rst mid-line -> all outputs are 0 immediately; after release, nothing is drawn until after the next vblnk rising edge.
